keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x3 matrix keypad, debounces it, and turns each distinct key press into a single-cycle key code on the 4-bit `invalue` bus that `safecontrol` consumes. It sits between the keypad pins and `safecontrol`, and drives that bus to the idle code 13 whenever no new press is being reported. Auto-repeat is not supported: a key must be released, with the release debounced, before another press can be reported.

## Interface
- `SCAN_CYCLES`, default 1000: clocks each row is driven. Must be ≥ 4.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical full-keypad frames needed to accept a press or a release. Must be ≥ 1.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `col_n` input 3: keypad columns, active-low, pulled up externally, asynchronous to `clk`.
- `row_n` output 4: keypad row drive, active-low, exactly one bit low at any time.
- `keycode` output 4: key code pulse to `safecontrol`, otherwise 13.
- `held` output 1: high while a debounced key is held (states HELD and RELEASE_WAIT).

## Operation
- **Key map** (row, col) to code:
  - Row 0: 1, 2, 3.
  - Row 1: 4, 5, 6.
  - Row 2: 7, 8, 9.
  - Row 3: * = 11, 0 = 0, # = 10.
  - Codes 12–15 are never emitted, and 13 means no command.
- **Synchronizer:** `col_n` passes through a 2-flop synchronizer, reset to 3'b111.
- **Scan:**
  - A `SCAN_CYCLES` slot counter advances the row index 0→1→2→3→0, and `row_n` is low only on the current row.
  - The synchronized columns are sampled on the last cycle of each slot (counter = `SCAN_CYCLES`-1).
  - Any low bit marks a pressed key in that row.
- **Frame:** the four row samples form one frame. The frame is classified on the row-3 sample cycle as:
  - NONE: zero keys pressed.
  - SINGLE(c): exactly one key pressed, with code c.
  - MULTI: two or more keys pressed.
- **FSM**, updated once per frame with counter `cnt` and candidate `cand`:
  - **IDLE**
    - On SINGLE(c): set `cand`=c and `cnt`=1. If `DEBOUNCE_FRAMES`=1, emit c and go to HELD; otherwise go to PRESS_WAIT.
    - On NONE or MULTI: stay in IDLE.
  - **PRESS_WAIT**
    - On SINGLE(`cand`): increment `cnt`. When `cnt` = `DEBOUNCE_FRAMES`, emit `cand` and go to HELD.
    - On SINGLE(c) with c≠`cand`: set `cand`=c and `cnt`=1.
    - On NONE or MULTI: clear `cnt` and go to IDLE.
  - **HELD**
    - On NONE: set `cnt`=1. Go to RELEASE_WAIT, or directly to IDLE if `DEBOUNCE_FRAMES`=1.
    - On SINGLE or MULTI: stay in HELD. A slide to another key or a second key is never emitted.
  - **RELEASE_WAIT**
    - On NONE: increment `cnt`. When `cnt` = `DEBOUNCE_FRAMES`, go to IDLE.
    - On SINGLE or MULTI: go back to HELD.
- **Widths:** `cnt` has enough bits to hold `DEBOUNCE_FRAMES` and saturates there. The slot counter and row index wrap naturally.
- **Reset values:**
  - `row_n`=4'b1110, `keycode`=13, `held`=0.
  - Slot counter 0, row index 0, state IDLE, `cnt`=0, `cand`=13.
- **Reset mid-operation:** reset drops everything, including a pending emission and any partial frame. A key that is still held after reset is emitted again once it has been stable for `DEBOUNCE_FRAMES` full frames.

## Timing
- One frame takes 4·`SCAN_CYCLES` clocks.
- A `col_n` change is visible to the sampler 2 clocks later. Because `SCAN_CYCLES` ≥ 4, each sample sees settled data.
- **Emission:** `keycode` equals the accepted code for exactly one clock, namely the cycle after the edge on which the accepting frame's row-3 sample is taken. It is 13 in every other cycle, so consecutive emissions are at least 2·`DEBOUNCE_FRAMES` frames apart.
- **Worst-case latency**, from a stable press to the `keycode` pulse: (`DEBOUNCE_FRAMES`+1)·4·`SCAN_CYCLES` + 3 clocks.
- **`held` timing:**
  - Rises in the same cycle as the `keycode` pulse.
  - Falls in the cycle after the frame that completes the release debounce.
- **Outputs:** `keycode`, `held` and `row_n` are all registered, with no combinational path from `col_n`.
- **Downstream contract:** `safecontrol` needs no handshake, but it must sample `keycode` every clock.

## Test plan
All scenarios use `SCAN_CYCLES`=4 and `DEBOUNCE_FRAMES`=2.
- **Reset state:** assert `rst` for 3 cycles → `keycode`=13, `held`=0, `row_n`=1110; after release, `row_n` rotates 1110→1101→1011→0111 every 4 clocks.
- **Single press:** hold key '5' (row 1, col 1) for 6 frames, then release → exactly one cycle with `keycode`=5 after the second matching frame; `held` high until 2 NONE frames have been seen.
- **Bounce rejection:** toggle '#' every frame for 4 frames, then hold it steady → no emission during the toggling; one pulse of 10 after 2 steady frames. Repeat with '*' → 11.
- **Multi-key and slide:** press '1' and '2' together from IDLE → nothing emitted. Hold '7' until it is emitted, then slide to '8' without releasing → no second pulse.
- **Release debounce:** while '0' is held, give one NONE frame then press '0' again → no new emission. A full 2-frame release then a re-press → second pulse with value 0.
- **Reset mid-operation:** hold '9', assert `rst` in PRESS_WAIT and again in HELD → outputs return to reset values; with '9' still held, exactly one new pulse of 9 arrives after 2 full frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner : 4x3 matrix keypad scanner with frame-based debouncing.
// Revision 1.0
// ============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] keycode,
  output logic       held
);

  localparam int             SW        = $clog2(SCAN_CYCLES);
  localparam int             CW        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [3:0]     IDLE_CODE = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b0000: code = 4'd1;
      4'b0001: code = 4'd2;
      4'b0010: code = 4'd3;
      4'b0100: code = 4'd4;
      4'b0101: code = 4'd5;
      4'b0110: code = 4'd6;
      4'b1000: code = 4'd7;
      4'b1001: code = 4'd8;
      4'b1010: code = 4'd9;
      4'b1100: code = 4'd11;
      4'b1101: code = 4'd0;
      4'b1110: code = 4'd10;
      default: code = IDLE_CODE;
    endcase
    return code;
  endfunction

  logic [2:0]    col_meta, col_sync;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    row_idx;
  logic [1:0]    acc_count;
  logic [3:0]    acc_code;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    cand, cand_n;
  logic          emit;

  logic          slot_end, frame_done;
  logic [2:0]    row_hits;
  logic [1:0]    row_pop, base_count, row_col, frame_count;
  logic [2:0]    hit_sum;
  logic [3:0]    frame_code;
  logic          is_none, is_single;

  // Per-row classification; frame_count saturates at 2 meaning "multiple keys".
  always_comb begin
    slot_end   = (slot_cnt == SLOT_LAST);
    frame_done = slot_end && (row_idx == 2'd3);
    row_hits   = ~col_sync;
    row_pop    = {1'b0, row_hits[0]} + {1'b0, row_hits[1]} + {1'b0, row_hits[2]};
    base_count = (row_idx == 2'd0) ? 2'd0 : acc_count;
    hit_sum    = {1'b0, base_count} + {1'b0, row_pop};
    frame_count = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    row_col    = row_hits[0] ? 2'd0 : (row_hits[1] ? 2'd1 : 2'd2);
    frame_code = (row_pop == 2'd1) ? key_code(row_idx, row_col) : acc_code;
    is_none    = (frame_count == 2'd0);
    is_single  = (frame_count == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta  <= 3'b111;
      col_sync  <= 3'b111;
      slot_cnt  <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      acc_count <= 2'd0;
      acc_code  <= IDLE_CODE;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
      if (slot_end) begin
        slot_cnt  <= '0;
        row_idx   <= row_idx + 2'd1;
        row_n     <= {row_n[2:0], row_n[3]};
        acc_count <= frame_count;
        acc_code  <= frame_code;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cand    <= IDLE_CODE;
      keycode <= IDLE_CODE;
      held    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cand    <= cand_n;
      keycode <= emit ? cand_n : IDLE_CODE;
      held    <= (state_n == S_HELD) || (state_n == S_RELEASE_WAIT);
    end
  end

  // The FSM only moves on the row-3 sample edge, when a full frame is known.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    emit    = 1'b0;
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    if (frame_done) begin
      case (state)
        S_IDLE: begin
          if (is_single) begin
            cand_n = frame_code;
            cnt_n  = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              emit    = 1'b1;
              state_n = S_HELD;
            end else begin
              state_n = S_PRESS_WAIT;
            end
          end
        end
        S_PRESS_WAIT: begin
          if (is_single && (frame_code == cand)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              emit    = 1'b1;
              state_n = S_HELD;
            end
          end else if (is_single) begin
            cand_n = frame_code;
            cnt_n  = CNT_ONE;
          end else begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (is_none) begin
            cnt_n   = CNT_ONE;
            state_n = (CNT_ONE == CNT_MAX) ? S_IDLE : S_RELEASE_WAIT;
          end
        end
        S_RELEASE_WAIT: begin
          if (is_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) state_n = S_IDLE;
          end else begin
            state_n = S_HELD;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner : directed self-checking bench for keypad_scanner.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  localparam int SC    = 4;
  localparam int DF    = 2;
  localparam int FRAME = 4 * SC;

  localparam logic [11:0] K1    = 12'b0000_0000_0001;
  localparam logic [11:0] K2    = 12'b0000_0000_0010;
  localparam logic [11:0] K5    = 12'b0000_0001_0000;
  localparam logic [11:0] K7    = 12'b0000_0100_0000;
  localparam logic [11:0] K8    = 12'b0000_1000_0000;
  localparam logic [11:0] K9    = 12'b0001_0000_0000;
  localparam logic [11:0] KSTAR = 12'b0010_0000_0000;
  localparam logic [11:0] K0    = 12'b0100_0000_0000;
  localparam logic [11:0] KHASH = 12'b1000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  keycode;
  logic        held;
  logic [11:0] keys = '0;

  int n_tests = 0;
  int n_fail  = 0;

  int         cyc        = 0;
  int         pulses     = 0;
  int         long_pulse = 0;
  int         bad_codes  = 0;
  int         pulse_cyc  = 0;
  logic [3:0] last_code  = 4'd13;
  logic [3:0] prev_kc    = 4'd13;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk     (clk),
    .rst     (rst),
    .col_n   (col_n),
    .row_n   (row_n),
    .keycode (keycode),
    .held    (held)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row line to its column line.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3 + c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_kc <= keycode;
    if (keycode != 4'd13) begin
      pulses    <= pulses + 1;
      last_code <= keycode;
      pulse_cyc <= cyc;
      if (prev_kc != 4'd13) long_pulse <= long_pulse + 1;
      if (keycode >= 4'd12) bad_codes <= bad_codes + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_keycode"}, 32'(keycode), 32'd13);
    check_val({tag, "_held"},    32'(held),    32'd0);
    check_val({tag, "_row_n"},   32'(row_n),   32'b1110);
  endtask

  task automatic bounce_then_hold(input logic [11:0] k, input int code, input string tag);
    int p0;
    p0 = pulses;
    for (int i = 0; i < 2; i++) begin
      keys = k;  ticks(FRAME);
      keys = '0; ticks(FRAME);
    end
    check_val({tag, "_bounce_quiet"}, 32'(pulses - p0), 32'd0);
    keys = k;
    ticks(4 * FRAME);
    check_val({tag, "_steady_count"}, 32'(pulses - p0), 32'd1);
    check_val({tag, "_steady_code"},  32'(last_code),   32'(code));
    keys = '0;
    ticks(4 * FRAME);
    check_val({tag, "_released"}, 32'(held), 32'd0);
  endtask

  // After reset release with key '9' held, the accepting frame is the second
  // frame, whose row-3 sample is taken on edge 2*FRAME.
  task automatic reset_repress(input string tag);
    for (int k = 1; k <= 2 * FRAME + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 2 * FRAME - 1) begin
        check_val({tag, "_pre_code"}, 32'(keycode), 32'd13);
        check_val({tag, "_pre_held"}, 32'(held),    32'd0);
      end else if (k == 2 * FRAME) begin
        check_val({tag, "_pulse_code"}, 32'(keycode), 32'd9);
        check_val({tag, "_pulse_held"}, 32'(held),    32'd1);
      end else if (k == 2 * FRAME + 1) begin
        check_val({tag, "_post_code"}, 32'(keycode), 32'd13);
      end
    end
  endtask

  initial begin
    int p0;
    int t0;

    // Reset state and row rotation.
    rst  = 1'b1;
    keys = '0;
    ticks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk);
      #1;
      case (k)
        1:  check_val("rot_e1",  32'(row_n), 32'b1110);
        4:  check_val("rot_e4",  32'(row_n), 32'b1101);
        8:  check_val("rot_e8",  32'(row_n), 32'b1011);
        12: check_val("rot_e12", 32'(row_n), 32'b0111);
        16: check_val("rot_e16", 32'(row_n), 32'b1110);
        default: ;
      endcase
    end

    // Single press of '5'.
    p0   = pulses;
    t0   = cyc;
    keys = K5;
    ticks(6 * FRAME);
    check_val("k5_count",   32'(pulses - p0), 32'd1);
    check_val("k5_code",    32'(last_code),   32'd5);
    check_val("k5_latency", 32'((pulse_cyc - t0) <= (DF + 1) * FRAME + 3), 32'd1);
    check_val("k5_held",    32'(held),        32'd1);
    keys = '0;
    ticks(FRAME);
    check_val("k5_held_after_1f", 32'(held), 32'd1);
    ticks(44);
    check_val("k5_held_released", 32'(held), 32'd0);
    check_val("k5_final_count",   32'(pulses - p0), 32'd1);

    // Bounce rejection.
    bounce_then_hold(KHASH, 10, "hash");
    bounce_then_hold(KSTAR, 11, "star");

    // Multi-key from idle, then slide while held.
    p0   = pulses;
    keys = K1 | K2;
    ticks(4 * FRAME);
    check_val("multi_count", 32'(pulses - p0), 32'd0);
    check_val("multi_held",  32'(held),        32'd0);
    keys = '0;
    ticks(2 * FRAME);
    keys = K7;
    ticks(4 * FRAME);
    check_val("k7_count", 32'(pulses - p0), 32'd1);
    check_val("k7_code",  32'(last_code),   32'd7);
    keys = K8;
    ticks(4 * FRAME);
    check_val("slide_count", 32'(pulses - p0), 32'd1);
    check_val("slide_held",  32'(held),        32'd1);
    keys = '0;
    ticks(4 * FRAME);
    check_val("slide_released", 32'(held), 32'd0);

    // Release debounce with '0'.
    p0   = pulses;
    keys = K0;
    ticks(4 * FRAME);
    check_val("k0_count", 32'(pulses - p0), 32'd1);
    check_val("k0_code",  32'(last_code),   32'd0);
    keys = '0;
    ticks(FRAME);
    keys = K0;
    ticks(3 * FRAME);
    check_val("k0_short_release_count", 32'(pulses - p0), 32'd1);
    check_val("k0_short_release_held",  32'(held),        32'd1);
    keys = '0;
    ticks(4 * FRAME);
    check_val("k0_full_release_held", 32'(held), 32'd0);
    keys = K0;
    ticks(4 * FRAME);
    check_val("k0_repress_count", 32'(pulses - p0), 32'd2);
    check_val("k0_repress_code",  32'(last_code),   32'd0);
    keys = '0;
    ticks(4 * FRAME);

    // Reset during PRESS_WAIT, then during HELD, with '9' held throughout.
    p0   = pulses;
    keys = K9;
    ticks(FRAME + 4);
    check_val("k9_pw_count", 32'(pulses - p0), 32'd0);
    rst = 1'b1;
    ticks(3);
    check_reset_outputs("rst_pw");
    rst = 1'b0;
    reset_repress("rst_pw");
    check_val("rst_pw_count", 32'(pulses - p0), 32'd1);
    ticks(8);
    rst = 1'b1;
    ticks(3);
    check_reset_outputs("rst_held");
    rst = 1'b0;
    reset_repress("rst_held");
    check_val("rst_held_count", 32'(pulses - p0), 32'd2);
    keys = '0;
    ticks(4 * FRAME);

    check_val("pulse_width",  32'(long_pulse), 32'd0);
    check_val("code_range",   32'(bad_codes),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
